// File: rtl/noc_pkg.sv
// Shared router definitions: default geometry, allocator state encoding and
// one-hot/index conversion helpers (vectors up to 16 ports).
package noc_pkg;

    localparam int NPORTS_DEF = 5;
    localparam int PORTW_DEF  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int unsigned onehot_to_idx(input logic [15:0] oh);
        int unsigned idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = 32'(i);
        end
        return idx;
    endfunction

    function automatic logic [15:0] idx_to_onehot(input int unsigned idx);
        return 16'(1) << idx;
    endfunction

endpackage

// File: rtl/outport_alloc_if.sv
// Per-output-port allocator bus: input flit qualifiers in, grant/select/busy out.
interface outport_alloc_if import noc_pkg::*; #(
    parameter int NPORTS = NPORTS_DEF,
    parameter int PORTW  = PORTW_DEF
);
    logic [NPORTS-1:0]       req;
    logic [NPORTS*PORTW-1:0] dst;
    logic [NPORTS-1:0]       mc;
    logic [NPORTS-1:0]       tail;
    logic                    credit_ok;
    logic [NPORTS-1:0]       grt;
    logic [NPORTS-1:0]       sel;
    logic                    busy;

    modport master (
        output req, dst, mc, tail, credit_ok,
        input  grt, sel, busy
    );

    modport slave (
        input  req, dst, mc, tail, credit_ok,
        output grt, sel, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of cand_i at or after ptr_i,
// wrapping, returned one-hot.
module rr_pick #(
    parameter int N = 5
) (
    input  logic [N-1:0]         cand_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         win_o
);
    logic [N-1:0] rot;
    logic [N-1:0] lo;

    // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back.
    assign rot   = N'({cand_i, cand_i} >> ptr_i);
    assign lo    = rot & (~rot + N'(1));
    assign win_o = N'(({lo, lo} << ptr_i) >> N);
endmodule

// File: rtl/outport_alloc.sv
// Wormhole switch allocator for one output port: round-robin head arbitration
// with optional multicast priority, head-to-tail lock, credit-gated grants.
//   state  | meaning
//   IDLE   | output free; heads arbitrate round-robin from ptr
//   LOCKED | packet from owner holds the output until its tail is granted
module outport_alloc import noc_pkg::*; #(
    parameter int NPORTS  = NPORTS_DEF,
    parameter int PORTW   = PORTW_DEF,
    parameter int PORTID  = 0,
    parameter int MC_PRIO = 1
) (
    input  logic           clk,
    input  logic           rst_,
    outport_alloc_if.slave bus
);
    localparam int IW = $clog2(NPORTS);

    state_t            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [IW-1:0]     gidx;
    logic [NPORTS-1:0] owner_q;
    logic [NPORTS-1:0] sel_q;
    logic              busy_q;
    logic [NPORTS-1:0] elig;
    logic [NPORTS-1:0] elig_mc;
    logic [NPORTS-1:0] cand;
    logic [NPORTS-1:0] win;
    logic [NPORTS-1:0] grt;
    logic              grt_tail;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NPORTS; i++) begin
            elig[i] = bus.req[i] && (bus.dst[i*PORTW +: PORTW] == PORTW'(PORTID));
        end
    end

    assign elig_mc = elig & bus.mc;
    assign cand    = ((MC_PRIO != 0) && (|elig_mc)) ? elig_mc : elig;

    rr_pick #(.N(NPORTS)) u_pick (
        .cand_i (cand),
        .ptr_i  (ptr_q),
        .win_o  (win)
    );

    // Body flits carry no routing, so a locked owner is granted on req alone.
    always_comb begin
        grt = '0;
        if (rst_ && bus.credit_ok) begin
            grt = (state_q == IDLE) ? win : (owner_q & bus.req);
        end
    end

    assign grt_tail = |(grt & bus.tail);
    assign gidx     = IW'(onehot_to_idx(16'(grt)));
    assign ptr_d    = (gidx == IW'(NPORTS - 1)) ? '0 : gidx + IW'(1);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            sel_q <= grt;
            case (state_q)
                IDLE: begin
                    if (|grt) begin
                        if (grt_tail) begin
                            ptr_q <= ptr_d;
                        end else begin
                            owner_q <= grt;
                            state_q <= LOCKED;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (grt_tail) begin
                        ptr_q   <= ptr_d;
                        owner_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    a_grt_onehot: assert property (@(posedge clk) disable iff (!rst_) $onehot0(grt));

    assign bus.grt  = grt;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
endmodule

// File: doc/outport_alloc.md
# outport_alloc

Parametrised per-output-port switch allocator for the wormhole router. One instance per output port resolves contention among all input ports. It grants the output to one packet at a time and holds it from head flit to tail flit. Multicast heads take priority over unicast heads, the winner is picked round-robin, and grants are gated by downstream credit. It drives the crossbar select for its output, one cycle after the grant.

## Interface
Parameters:
- NPORTS, 5, number of input ports (2..16)
- PORTW, 3, width of each per-input destination-port field
- PORTID, 0, index of the output port this instance owns
- MC_PRIO, 1, 1 = multicast heads pre-empt unicast heads in arbitration; 0 = all heads equal

Ports:
- clk  in  1  clock; all state on rising edge
- rst_  in  1  reset, asynchronous, active-low
- req  in  NPORTS  per-input flit valid
- dst  in  NPORTS*PORTW  per-input requested output port; field i at [i*PORTW +: PORTW]
- mc  in  NPORTS  per-input multicast flag, meaningful on head flits only
- tail  in  NPORTS  per-input last-flit-of-packet flag (single-flit packet: head and tail together)
- credit_ok  in  1  downstream buffer can accept one flit this cycle
- grt  out  NPORTS  one-hot or zero grant, combinational, same cycle
- sel  out  NPORTS  registered crossbar select, one-hot or zero
- busy  out  1  registered; 1 while a packet holds the output (state LOCKED)

## Operation
- Eligible head: e[i] = req[i] & (dst[i] == PORTID).
- Multicast mask, IDLE only: if MC_PRIO and |(e & mc), the candidate set is c = e & mc; otherwise c = e.
- States:
  - IDLE:
    - If credit_ok and |c: grt = round-robin pick of c.
    - Starting at ptr, search ptr, ptr+1, … NPORTS-1, 0, … ptr-1; first set bit wins.
    - The winner is latched into owner.
    - If tail[winner] is set, stay in IDLE and set ptr = winner+1 mod NPORTS.
    - Otherwise go to LOCKED.
  - LOCKED:
    - grt = owner & req & {NPORTS{credit_ok}}.
    - dst and mc of the owner are NOT checked: body flits carry no routing.
    - Other inputs are never granted.
    - If granted and tail[owner]: go to IDLE, ptr = owner+1 mod NPORTS, clear owner.
- Owner req low in LOCKED: zero grant, no state change (bubble). The lock is not lost.
- credit_ok low in any state: grt = 0, no state/ptr/owner change.
- ptr wraps: winner NPORTS-1 gives ptr 0.
- sel <= grt every cycle, so sel is zero in cycles after a non-grant.
- busy = (state == LOCKED).
- grt never has more than one bit set. Verify with an assertion.

## Timing
- Reset (async assert, held): state IDLE, ptr 0, owner 0, sel 0, busy 0. grt is 0 while rst_ is low.
- Reset mid-packet: the lock is dropped immediately. The next head after release arbitrates from ptr 0.
- Grant latency: 0 cycles (grt combinational from req, dst, mc, tail, credit_ok and state).
- sel latency: 1 cycle after grt (crossbar traversal stage).
- busy rises the cycle after a non-tail head grant. It falls the cycle after the tail grant.
- Back-to-back packets: a tail grant in cycle t allows a new head grant in cycle t+1, using the updated ptr. There is no dead cycle.
- Head+tail from the same input in IDLE: grant, stay IDLE, ptr advances.
- Multicast head arriving while LOCKED: waits until after the tail. It has no pre-emption of an in-flight packet.

## Structure
- Shared package noc_pkg holds:
  - default NPORTS and PORTW
  - state enum {IDLE, LOCKED}
  - onehot-to-index and index-to-onehot functions
- Sub-module rr_pick: purely combinational, parameter N. Inputs are the candidate vector and ptr index; output is the one-hot winner.
- outport_alloc contains the eligibility/mask logic, the state machine, the ptr/owner registers and the sel register.

## Test plan
- Round-robin fairness:
  - Stimulus: NPORTS=5, PORTID=2, inputs 0, 1, 3 each send continuous single-flit packets to port 2, credit_ok=1.
  - Required: grants cycle 0, 1, 3, 0, 1, 3.
  - Required: sel follows grt one cycle later.
- Multicast priority:
  - Stimulus: inputs 0 and 4 unicast heads, input 3 multicast head, same cycle, ptr=0.
  - Required: input 3 granted first; with MC_PRIO=0, input 0 granted.
- Wormhole hold:
  - Stimulus: input 1 sends a 4-flit packet. Input 0 requests throughout. Input 1's req drops for 2 cycles mid-packet.
  - Required: only input 1 is granted until its tail. busy=1 during that span.
  - Required: input 0 is granted the cycle after input 1's tail grant.
- Credit stall:
  - Stimulus: credit_ok=0 for 3 cycles during a LOCKED packet.
  - Required: grt=0 during the stall, owner unchanged, transfer resumes on the owner.
- ptr wrap:
  - Stimulus: a single-flit grant to input 4.
  - Required: ptr=0; inputs 0 and 3 then both request; input 0 wins.
- Async reset:
  - Stimulus: assert rst_ low mid-packet, between clock edges.
  - Required: busy, sel and grt go to 0 immediately.
  - Required: after release, input 2's head is granted even though the old owner still requests with a body flit (dst != PORTID).
